// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file's single write port (ALU vs MEM).
// Optional REGFILE_WB_INIT_EN: after reset, zero x1..x(NREG-1) one per cycle before accepting requests.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  typedef enum logic [1:0] {RST, INIT, RUN} state_t;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t  state, state_nxt;
  logic    ptr;      // last winner: 0 = ALU, 1 = MEM
  logic    alu_go, mem_go;
  wb_req_t win;

  always_comb begin
    state_nxt = state;
    alu_go    = 1'b0;
    mem_go    = 1'b0;
    case (state)
`ifdef REGFILE_WB_INIT_EN
      RST:  state_nxt = INIT;
`else
      RST:  state_nxt = RUN;
`endif
      INIT: if (rf_rd == LAST_IDX) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    // Gating with reset makes a same-cycle reset cancel the handshake.
    if (state == RUN && !reset) begin
      if (alu_valid && mem_valid) begin
        mem_go = ~ptr;
        alu_go = ptr;
      end else begin
        alu_go = alu_valid;
        mem_go = mem_valid;
      end
    end
    win = mem_go ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RST;
      ptr      <= 1'b0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      rf_we <= 1'b0;
      if (alu_go || mem_go) begin
        ptr <= mem_go;
        if (win.rd != '0) begin
          rf_we    <= 1'b1;
          rf_rd    <= win.rd;
          rf_wdata <= win.data;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
`ifdef REGFILE_WB_INIT_EN
      // rf_rd doubles as the init walk index.
      if (state == RST || (state == INIT && rf_rd != LAST_IDX)) begin
        rf_we    <= 1'b1;
        rf_rd    <= (state == RST) ? AW'(1) : rf_rd + AW'(1);
        rf_wdata <= '0;
      end
`endif
    end
  end

  assign alu_ready = alu_go;
  assign mem_ready = mem_go;
  assign busy      = (state != RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, rf_we, busy;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [7:0]      drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  // Assert reset for two edges, release it; returns at the negedge after the first reset-free edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 5, 64'h11, 1, 6, 64'h22);
    #1;
    vectors++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata, drop_cnt, busy} !== {1'b0, 5'd0, 64'd0, 8'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values got we=%b rd=%0d wd=%h drop=%0d busy=%b exp 0/0/0/0/1",
               rf_we, rf_rd, rf_wdata, drop_cnt, busy);
    end
    set_in(0, 0, 0, 0, 0, 0);
    do_reset();
  endtask

  task automatic test_single();
    set_in(1, 5, 64'hAB, 0, 0, 0);
    #1;
    vectors++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      miscompares++; $display("FAIL single_ready got=%b exp=10", {alu_ready, mem_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 64'hAB}) begin
      miscompares++; $display("FAIL single_write got we=%b rd=%0d wd=%h exp 1/5/ab", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b0, 5'd5, 64'hAB}) begin
      miscompares++; $display("FAIL single_idle got we=%b rd=%0d wd=%h exp 0/5/ab", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    do_reset();
    set_in(1, 3, 64'h33, 1, 4, 64'h44);
    #1;
    vectors++;
    if ({alu_ready, mem_ready} !== 2'b01) begin
      miscompares++; $display("FAIL conflict_first got=%b exp=01", {alu_ready, mem_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd4, 64'h44}) begin
      miscompares++; $display("FAIL conflict_wr1 got we=%b rd=%0d exp 1/4", rf_we, rf_rd);
    end
    @(negedge clk);
    set_in(1, 3, 64'h33, 0, 0, 0);
    #1;
    vectors++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      miscompares++; $display("FAIL conflict_second got=%b exp=10", {alu_ready, mem_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 64'h33}) begin
      miscompares++; $display("FAIL conflict_wr2 got we=%b rd=%0d exp 1/3", rf_we, rf_rd);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  // ALU won last, so MEM opens; alternation expected M,A,M,A,M,A.
  task automatic test_back_to_back();
    logic [AW-1:0] ard, mrd;
    logic [XLEN-1:0] ad, md;
    int writes = 0;
    ard = 5'd10; ad = 64'hA0; mrd = 5'd20; md = 64'hB0;
    for (int i = 0; i < 6; i++) begin
      logic exp_mem;
      exp_mem = (i % 2 == 0);
      set_in(1, ard, ad, 1, mrd, md);
      #1;
      vectors++;
      if ({alu_ready, mem_ready} !== {~exp_mem, exp_mem}) begin
        miscompares++; $display("FAIL b2b_grant%0d got=%b exp=%b", i, {alu_ready, mem_ready}, {~exp_mem, exp_mem});
      end
      @(posedge clk); #1;
      vectors++;
      if ({rf_we, rf_rd, rf_wdata} !== {1'b1, exp_mem ? mrd : ard, exp_mem ? md : ad}) begin
        miscompares++; $display("FAIL b2b_write%0d got we=%b rd=%0d wd=%h", i, rf_we, rf_rd, rf_wdata);
      end
      if (rf_we) writes++;
      if (exp_mem) begin mrd = mrd + 1; md = md + 1; end
      else begin ard = ard + 1; ad = ad + 1; end
      @(negedge clk);
    end
    vectors++;
    if (writes != 6) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=6", writes);
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_x0_drop();
    do_reset();
    set_in(1, 0, 64'hFF, 0, 0, 0);
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++; $display("FAIL x0_ready got=%b exp=1", alu_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, drop_cnt} !== {1'b0, 8'd1}) begin
      miscompares++; $display("FAIL x0_first got we=%b drop=%0d exp 0/1", rf_we, drop_cnt);
    end
    for (int i = 1; i < 300; i++) begin
      @(posedge clk); #1;
      if (rf_we !== 1'b0) begin
        vectors++; miscompares++; $display("FAIL x0_we_loop%0d got=%b exp=0", i, rf_we);
      end
    end
    vectors++;
    if (drop_cnt !== 8'd255) begin
      miscompares++; $display("FAIL x0_saturate got=%0d exp=255", drop_cnt);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_in(1, 7, 64'h77, 1, 8, 64'h88);
    reset = 1'b1;
    #1;
    vectors++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_ready got=%b exp=00", {alu_ready, mem_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, busy, alu_ready, mem_ready} !== 4'b0100) begin
      miscompares++; $display("FAIL rstmid_after got we=%b busy=%b rdy=%b%b exp 0/1/00", rf_we, busy, alu_ready, mem_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_init();
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 9, 64'h99, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (alu_ready !== 1'b0) begin
      miscompares++; $display("FAIL init_cycle0_ready got=%b exp=0", alu_ready);
    end
    @(negedge clk);
`ifdef REGFILE_WB_INIT_EN
    for (int idx = 1; idx <= 31; idx++) begin
      #1;
      vectors++;
      if ({rf_we, rf_rd, rf_wdata, busy, alu_ready} !== {1'b1, 5'(idx), 64'd0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL init_walk%0d got we=%b rd=%0d wd=%h busy=%b rdy=%b", idx, rf_we, rf_rd, rf_wdata, busy, alu_ready);
      end
      @(negedge clk);
    end
`endif
    #1;
    vectors++;
    if ({alu_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL init_first_grant got rdy=%b busy=%b exp 1/0", alu_ready, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd9, 64'h99}) begin
      miscompares++; $display("FAIL init_grant_write got we=%b rd=%0d wd=%h", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  // Producers hold each request until accepted; model tracks who was served last.
  task automatic test_random();
    logic a_v = 0, m_v = 0;
    logic [AW-1:0] a_rd = 0, m_rd = 0;
    logic [XLEN-1:0] a_d = 0, m_d = 0;
    int last_mem = 0;
    int drops = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic ea, em, exp_we;
      logic [AW-1:0] exp_rd;
      logic [XLEN-1:0] exp_wd;
      if (!a_v) begin
        a_v = ($urandom_range(0, 2) != 0);
        a_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        a_d = {$urandom, $urandom};
      end
      if (!m_v) begin
        m_v = ($urandom_range(0, 2) != 0);
        m_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        m_d = {$urandom, $urandom};
      end
      set_in(a_v, a_rd, a_d, m_v, m_rd, m_d);
      if (a_v && m_v) begin em = (last_mem == 0); ea = !em; end
      else begin ea = a_v; em = m_v; end
      #1;
      vectors++;
      if ({alu_ready, mem_ready} !== {ea, em}) begin
        miscompares++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, {alu_ready, mem_ready}, {ea, em});
      end
      exp_we = 1'b0; exp_rd = 0; exp_wd = 0;
      if (ea || em) begin
        exp_rd = em ? m_rd : a_rd;
        exp_wd = em ? m_d : a_d;
        last_mem = em ? 1 : 0;
        if (exp_rd == 0) drops = (drops < 255) ? drops + 1 : 255;
        else exp_we = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if (rf_we !== exp_we || (exp_we && {rf_rd, rf_wdata} !== {exp_rd, exp_wd}) || drop_cnt !== 8'(drops)) begin
        miscompares++;
        $display("FAIL rand_out c=%0d got we=%b rd=%0d wd=%h drop=%0d exp we=%b rd=%0d wd=%h drop=%0d",
                 c, rf_we, rf_rd, rf_wdata, drop_cnt, exp_we, exp_rd, exp_wd, drops);
      end
      if (ea) a_v = 0;
      if (em) m_v = 0;
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_conflict();
    test_back_to_back();
    test_x0_drop();
    test_reset_mid();
    test_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout exp=finish");
    $fatal(1);
  end
endmodule
